// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: 8086-style bus cycle sequencer with T1..T4/TW wait states and HOLD/HLDA arbitration.
module bus_cycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_wr,
  input  logic        req_io,
  input  logic [19:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic        req_bhe_n,
  input  logic [1:0]  req_seg,
  output logic        ack,
  output logic [15:0] rdata,
  output logic [15:0] ad_out,
  output logic        ad_oe,
  input  logic [15:0] ad_in,
  output logic [3:0]  a_hi,
  output logic        bhe_n,
  output logic        ale,
  output logic        rd_n,
  output logic        wr_n,
  output logic        m_io,
  output logic        dt_r_n,
  output logic        den_n,
  output logic        bus_oe,
  input  logic        ready,
  input  logic        hold,
  output logic        hlda
);
  typedef enum logic [2:0] {IDLE, T1, T2, T3, TW, T4, HOLD} state_t;
  state_t state, state_nx;
  logic        wr_q, io_q, bhe_q;
  logic [19:0] addr_q;
  logic [15:0] wdata_q;
  logic [1:0]  seg_q;
  logic        in_cyc, data_ph;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // request fields are captured on every entry to T1 so the bus never sees req* directly
  always_ff @(posedge clk)
    if (rst) begin
      wr_q    <= 1'b0;
      io_q    <= 1'b0;
      bhe_q   <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      seg_q   <= '0;
    end else if (state_nx == T1) begin
      wr_q    <= req_wr;
      io_q    <= req_io;
      bhe_q   <= req_bhe_n;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      seg_q   <= req_seg;
    end
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if ((state == T3 || state == TW) && ready && !wr_q) rdata <= ad_in;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = hold ? HOLD : req ? T1 : IDLE;
      T1:      state_nx = T2;
      T2:      state_nx = T3;
      T3, TW:  state_nx = ready ? T4 : TW;
      T4:      state_nx = hold ? HOLD : req ? T1 : IDLE;
      HOLD:    state_nx = hold ? HOLD : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  assign in_cyc  = state inside {T1, T2, T3, TW, T4};
  assign data_ph = state inside {T2, T3, TW};
  assign ale     = state == T1;
  assign ack     = state == T4;
  assign hlda    = state == HOLD;
  assign bus_oe  = state != HOLD;
  assign ad_oe   = ale | (data_ph & wr_q);
  assign ad_out  = ale ? addr_q[15:0] : (data_ph & wr_q) ? wdata_q : 16'h0000;
  assign a_hi    = ale ? addr_q[19:16] : in_cyc ? {2'b00, seg_q} : 4'h0;
  assign bhe_n   = in_cyc ? bhe_q : 1'b1;
  assign rd_n    = !(data_ph & !wr_q);
  assign wr_n    = !(data_ph & wr_q);
  assign den_n   = !data_ph;
  assign m_io    = in_cyc ? !io_q : 1'b1;
  assign dt_r_n  = in_cyc ? wr_q : 1'b1;
endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb_bus_cycle_ctrl: directed checks of bus_cycle_ctrl timing, waits, hold and reset.
module tb_bus_cycle_ctrl;
  logic        clk = 0, rst = 1, req = 0, req_wr = 0, req_io = 0, req_bhe_n = 1;
  logic [19:0] req_addr = '0;
  logic [15:0] req_wdata = '0, ad_in = '0;
  logic [1:0]  req_seg = '0;
  logic        ready = 1, hold = 0;
  logic        ack, ad_oe, bhe_n, ale, rd_n, wr_n, m_io, dt_r_n, den_n, bus_oe, hlda;
  logic [15:0] rdata, ad_out;
  logic [3:0]  a_hi;
  int total = 0, bad = 0;
  bus_cycle_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_io(req_io),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_bhe_n(req_bhe_n), .req_seg(req_seg),
    .ack(ack), .rdata(rdata), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in),
    .a_hi(a_hi), .bhe_n(bhe_n), .ale(ale), .rd_n(rd_n), .wr_n(wr_n), .m_io(m_io),
    .dt_r_n(dt_r_n), .den_n(den_n), .bus_oe(bus_oe), .ready(ready), .hold(hold), .hlda(hlda)
  );
  always #5 clk = ~clk;
  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // {ale,rd_n,wr_n,den_n,dt_r_n,m_io,ad_oe,bus_oe,hlda,ack,bhe_n} at rest
  task chk_idle(input string tag, input logic [15:0] rd_exp);
    chk({tag, "_ctl"}, {ale, rd_n, wr_n, den_n, dt_r_n, m_io, ad_oe, bus_oe, hlda, ack, bhe_n}, 11'b0_1111_1_0_1_0_0_1);
    chk({tag, "_rdata"}, rdata, rd_exp);
    chk({tag, "_ad"}, {a_hi, ad_out}, 20'h0);
  endtask
  task xfer(input string tag, input logic w, input logic io, input logic [19:0] a,
            input logic [15:0] wd, input logic [1:0] sg, input int waits, input logic [15:0] din);
    int n_ack, lo;
    n_ack = 0;
    lo = 0;
    req_wr = w; req_io = io; req_addr = a; req_wdata = wd; req_seg = sg; req_bhe_n = 0;
    ad_in = din; req = 1;
    for (int n = 1; n <= 20 && n_ack == 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk({tag, "_t1_ale"}, {ale, ad_oe, bhe_n}, 3'b110);
        chk({tag, "_t1_addr"}, {a_hi, ad_out}, a);
        chk({tag, "_t1_mio_dtr"}, {m_io, dt_r_n}, {!io, w});
      end
      if (n == 2) begin
        chk({tag, "_t2_ahi"}, a_hi, {2'b00, sg});
        chk({tag, "_t2_oe_den"}, {ad_oe, den_n, ale, m_io, dt_r_n}, {w, 1'b0, 1'b0, !io, w});
        if (w) chk({tag, "_t2_wdata"}, ad_out, wd);
      end
      if (w ? !wr_n : !rd_n) lo++;
      ready = !(n >= 3 && n < 3 + waits);
      if (ack) begin
        n_ack = n;
        req = 0;
        ready = 1;
        chk({tag, "_t4_strobes"}, {rd_n, wr_n, den_n, ad_oe}, 4'b1110);
      end
    end
    chk({tag, "_ack_cycle"}, n_ack, 4 + waits);
    chk({tag, "_strobe_len"}, lo, 2 + waits);
    if (!w) chk({tag, "_rdata"}, rdata, din);
  endtask
  initial begin
    int acks;
    repeat (2) @(negedge clk);
    chk_idle("reset", 16'h0);
    rst = 0;
    @(negedge clk);
    chk_idle("idle", 16'h0);
    xfer("mem_rd", 0, 0, 20'h2A5C4, 16'h0, 2'd2, 0, 16'hBEEF);
    @(negedge clk);
    chk_idle("after_rd", 16'hBEEF);
    xfer("io_wr", 1, 1, 20'h00060, 16'h1234, 2'd1, 0, 16'hDEAD);
    @(negedge clk);
    chk_idle("after_wr", 16'hBEEF);
    xfer("wait_rd", 0, 0, 20'h81234, 16'h0, 2'd3, 3, 16'hC0DE);
    @(negedge clk);
    // back-to-back: req stays high for three transfers
    acks = 0;
    req_wr = 0; req_io = 0; req_addr = 20'h12345; ad_in = 16'h5555; req = 1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (ack) acks++;
      if (n % 4 == 0) chk($sformatf("b2b_ack%0d", n), ack, 1'b1);
      if (n % 4 == 1) chk($sformatf("b2b_t1_%0d", n), ale, 1'b1);
      if (n == 4) begin
        req_addr = 20'h54321;
        ad_in = 16'h6666;
      end
      if (n == 5) chk("b2b_relatch", {a_hi, ad_out}, 20'h54321);
      if (n == 12) begin
        req = 0;
        chk("b2b_rdata", rdata, 16'h6666);
      end
    end
    chk("b2b_acks", acks, 3);
    @(negedge clk);
    chk_idle("after_b2b", 16'h6666);
    // hold raised mid-cycle, request left pending through HOLD
    req_addr = 20'h0ABCD; req_seg = 2'd1; ad_in = 16'h0F0F; req = 1;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      if (n == 2) hold = 1;
      if (n == 3) chk("hold_t3_rd", rd_n, 1'b0);
      if (n == 4) chk("hold_t4_ack", ack, 1'b1);
      if (n == 5) chk("hold_state", {hlda, bus_oe, ad_oe, rd_n, wr_n, den_n, ale, ack}, 8'b1001_1100);
      if (n == 6) begin
        chk("hold_still", hlda, 1'b1);
        hold = 0;
      end
      if (n == 7) chk("hold_exit_idle", {hlda, bus_oe, ale}, 3'b010);
      if (n == 8) chk("hold_pending_t1", ale, 1'b1);
      if (n == 11) begin
        chk("hold_pending_ack", ack, 1'b1);
        req = 0;
      end
    end
    @(negedge clk);
    chk_idle("after_hold", 16'h0F0F);
    // reset during TW, with req and hold both asserted
    ad_in = 16'h7777; req = 1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) ready = 0;
      if (n == 4) begin
        chk("tw_rd_low", {rd_n, ack}, 2'b00);
        rst = 1;
        hold = 1;
      end
    end
    @(negedge clk);
    chk_idle("rst_in_tw", 16'h0);
    rst = 0; req = 0; hold = 0; ready = 1;
    @(negedge clk);
    chk_idle("post_rst", 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
